// File: rtl/hbus_tx.sv
// hbus initiator: valid/ready commands become single-cycle hbus beats separated by GAP_CYCLES idle cycles.
// Accept->hen 1 cycle, beat->rsp_valid 1 cycle; an unconsumed read response stalls further beats.
module hbus_tx #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_incr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              wr_done,
  output logic              busy,
  output logic              hen,
  output logic              hwr_rd,
  output logic [ADDR_W-1:0] haddr,
  inout  wire  [DATA_W-1:0] hdata
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_GAP, S_RSP_WAIT} state_t;

  state_t             state_q, state_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               hen_q, hen_d;
  logic               hwr_rd_q, hwr_rd_d;
  logic [ADDR_W-1:0]  haddr_q, haddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               wr_q, wr_d;
  logic               incr_q, incr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_last_q, rsp_last_d;
  logic               wr_done_q, wr_done_d;
  logic               start_beat, go_idle;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    hen_d       = 1'b0;
    hwr_rd_d    = 1'b0;
    haddr_d     = haddr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    incr_d      = incr_q;
    cnt_d       = cnt_q;
    gap_cnt_d   = gap_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_last_d  = rsp_last_q;
    wr_done_d   = 1'b0;
    start_beat  = 1'b0;
    go_idle     = 1'b0;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d  = S_BEAT;
          hen_d    = 1'b1;
          hwr_rd_d = cmd_wr;
          haddr_d  = cmd_addr;
          wdata_d  = cmd_wdata;
          wr_d     = cmd_wr;
          incr_d   = cmd_incr;
          // cnt holds the beats still to run after the current one
          cnt_d    = cmd_wr ? '0 : cmd_len;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      S_BEAT: begin
        state_d   = S_GAP;
        gap_cnt_d = GW'(GAP_CYCLES - 1);
        if (wr_q) begin
          wr_done_d = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = hdata;
          rsp_last_d  = (cnt_q == '0);
        end
      end
      S_GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end else if (rsp_valid_q && !rsp_ready) begin
          state_d = S_RSP_WAIT;
        end else if (cnt_q != '0) begin
          start_beat = 1'b1;
        end else begin
          go_idle = 1'b1;
        end
      end
      S_RSP_WAIT: begin
        if (rsp_ready) begin
          if (cnt_q != '0) start_beat = 1'b1;
          else             go_idle    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_beat) begin
      state_d  = S_BEAT;
      hen_d    = 1'b1;
      hwr_rd_d = wr_q;
      haddr_d  = incr_q ? haddr_q + ADDR_W'(1) : haddr_q;
      cnt_d    = cnt_q - LEN_W'(1);
    end
    if (go_idle) begin
      state_d     = S_IDLE;
      cmd_ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      hen_q       <= 1'b0;
      hwr_rd_q    <= 1'b0;
      haddr_q     <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      incr_q      <= 1'b0;
      cnt_q       <= '0;
      gap_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_last_q  <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      hen_q       <= hen_d;
      hwr_rd_q    <= hwr_rd_d;
      haddr_q     <= haddr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      incr_q      <= incr_d;
      cnt_q       <= cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_last_q  <= rsp_last_d;
      wr_done_q   <= wr_done_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = (state_q != S_IDLE);
  assign hen       = hen_q;
  assign hwr_rd    = hwr_rd_q;
  assign haddr     = haddr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_last  = rsp_last_q;
  assign wr_done   = wr_done_q;
  assign hdata     = (hen_q && hwr_rd_q) ? wdata_q : {DATA_W{1'bz}};

endmodule
